// File: rtl/bsg_hash_bank_arb.sv
// ---------------------------------------------------------------------------
// | Module : bsg_hash_bank_arb                                              |
// | Hashes each requester address to (bank, index), arbitrates round-robin  |
// | per bank, and holds each winner in a one-entry register per bank.       |
// | Revision: 1.0                                                           |
// ---------------------------------------------------------------------------
`default_nettype none

package bsg_hash_bank_pkg;

  // Bank hash for banks = 2^n * (2^m - 1).
  // The low n address bits select among the power-of-two copies. The
  // remaining bits are consumed m at a time from the top. A chunk that is not
  // all-ones names the bank, and the bits below it form the index, offset by
  // the entries already used on earlier levels. An all-ones chunk spills to
  // the next level down. Leftover bits narrower than m name the bank
  // directly. With no bits left at all, the entry lands in bank 0.
  function automatic int hash_f(input int addr, input int banks, input int width,
                                input logic want_bank);
    int   n, odd, m, ones, low, a, hw, rem, offset, bank, idx, chunk;
    logic done;
    n = 0;
    for (int i = 0; i < 31; i++)
      if ((n == i) && (((banks >> i) & 1) == 0)) n = i + 1;
    odd    = banks >> n;
    m      = $clog2(odd + 1);
    ones   = (1 << m) - 1;
    low    = addr & ((1 << n) - 1);
    a      = addr >> n;
    hw     = width - n;
    bank   = 0;
    idx    = 0;
    offset = 0;
    done   = 1'b0;
    // A single odd bank: the upper bits are the index as-is
    if (m <= 1) begin
      idx  = a;
      done = 1'b1;
    end
    for (int k = 0; k <= 32; k++) begin
      if (!done) begin
        rem = hw - m * k;
        if (rem >= m) begin
          chunk = (a >> (rem - m)) & ones;
          if (chunk != ones) begin
            bank = chunk;
            idx  = offset + (a & ((1 << (rem - m)) - 1));
            done = 1'b1;
          end else begin
            offset = offset + (1 << (rem - m));
          end
        end else begin
          bank = a & ((1 << rem) - 1);
          idx  = offset;
          done = 1'b1;
        end
      end
    end
    bank = (bank << n) | low;
    return want_bank ? bank : idx;
  endfunction

  // The all-ones address always yields the largest index, so it sizes the
  // index field
  function automatic int index_width_f(input int banks, input int width);
    int idx_max;
    idx_max = hash_f((1 << width) - 1, banks, width, 1'b0);
    return (idx_max > 0) ? $clog2(idx_max + 1) : 1;
  endfunction

  // True when banks has the form 2^n * (2^m - 1) and the address is wide
  // enough to hold the power-of-two bank bits
  function automatic logic supported_f(input int banks, input int width);
    int n, odd;
    if (banks < 1 || width < 1 || width > 30) return 1'b0;
    n = 0;
    for (int i = 0; i < 31; i++)
      if ((n == i) && (((banks >> i) & 1) == 0)) n = i + 1;
    odd = banks >> n;
    return (((odd + 1) & odd) == 0) && (width >= n);
  endfunction

endpackage

module bsg_hash_bank_arb #(
  parameter  int els_p          = 2,
  parameter  int banks_p        = 3,
  parameter  int width_p        = 4,
  parameter  int data_width_p   = 32,
  localparam int index_width_lp = bsg_hash_bank_pkg::index_width_f(banks_p, width_p),
  localparam int lg_els_lp      = (els_p > 1) ? $clog2(els_p) : 1
) (
  input  logic                                clk_i,
  input  logic                                reset_n_i,
  input  logic [els_p-1:0]                    v_i,
  input  logic [els_p*width_p-1:0]            addr_i,
  input  logic [els_p*data_width_p-1:0]       data_i,
  output logic [els_p-1:0]                    ready_o,
  output logic [banks_p-1:0]                  v_o,
  output logic [banks_p*index_width_lp-1:0]   index_o,
  output logic [banks_p*data_width_p-1:0]     data_o,
  output logic [banks_p*lg_els_lp-1:0]        src_id_o,
  input  logic [banks_p-1:0]                  ready_i
);

  localparam int lg_banks_lp = (banks_p > 1) ? $clog2(banks_p) : 1;

  if (!bsg_hash_bank_pkg::supported_f(banks_p, width_p) || els_p < 1) begin : g_bad_params
    $error("bsg_hash_bank_arb: banks_p=%0d / width_p=%0d / els_p=%0d not supported",
           banks_p, width_p, els_p);
  end

  logic [lg_banks_lp-1:0]    req_bank  [els_p];
  logic [index_width_lp-1:0] req_index [els_p];
  logic [data_width_p-1:0]   req_data  [els_p];

  logic                      can_load  [banks_p];
  logic                      grant     [banks_p];
  logic [lg_els_lp-1:0]      winner    [banks_p];

  logic                      slot_v    [banks_p];
  logic [index_width_lp-1:0] slot_index[banks_p];
  logic [data_width_p-1:0]   slot_data [banks_p];
  logic [lg_els_lp-1:0]      slot_src  [banks_p];
  logic [lg_els_lp-1:0]      ptr       [banks_p];

  // Hash every requester's address and unpack its payload
  always_comb begin
    int a;
    for (int r = 0; r < els_p; r++) begin
      a            = int'(addr_i[r*width_p +: width_p]);
      req_bank[r]  = lg_banks_lp'(bsg_hash_bank_pkg::hash_f(a, banks_p, width_p, 1'b1));
      req_index[r] = index_width_lp'(bsg_hash_bank_pkg::hash_f(a, banks_p, width_p, 1'b0));
      req_data[r]  = data_i[r*data_width_p +: data_width_p];
    end
  end

  // Per-bank round-robin: scan from ptr+1 upward, wrapping, for the first
  // valid requester that hashes to this bank
  always_comb begin
    int cand;
    for (int b = 0; b < banks_p; b++) begin
      can_load[b] = reset_n_i && (!slot_v[b] || ready_i[b]);
      grant[b]    = 1'b0;
      winner[b]   = '0;
      for (int k = 1; k <= els_p; k++) begin
        cand = int'(ptr[b]) + k;
        if (cand >= els_p) cand = cand - els_p;
        if (!grant[b] && v_i[cand] && (req_bank[cand] == lg_banks_lp'(b))) begin
          grant[b]  = 1'b1;
          winner[b] = lg_els_lp'(cand);
        end
      end
      grant[b] = grant[b] && can_load[b];
    end
  end

  // A requester hashes to one bank only, so ready_o is the OR of the grants
  always_comb begin
    ready_o = '0;
    for (int b = 0; b < banks_p; b++)
      if (grant[b]) ready_o[winner[b]] = 1'b1;
  end

  // Output slots and arbiter pointers; a load may coincide with a dequeue
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int b = 0; b < banks_p; b++) begin
        slot_v[b]     <= 1'b0;
        slot_index[b] <= '0;
        slot_data[b]  <= '0;
        slot_src[b]   <= '0;
        ptr[b]        <= lg_els_lp'(els_p - 1);
      end
    end else begin
      for (int b = 0; b < banks_p; b++) begin
        if (grant[b]) begin
          slot_v[b]     <= 1'b1;
          slot_index[b] <= req_index[winner[b]];
          slot_data[b]  <= req_data[winner[b]];
          slot_src[b]   <= winner[b];
          ptr[b]        <= winner[b];
        end else if (ready_i[b]) begin
          slot_v[b]     <= 1'b0;
        end
      end
    end
  end

  for (genvar b = 0; b < banks_p; b++) begin : g_bank_out
    assign v_o[b]                                      = slot_v[b];
    assign index_o[b*index_width_lp +: index_width_lp] = slot_index[b];
    assign data_o[b*data_width_p +: data_width_p]      = slot_data[b];
    assign src_id_o[b*lg_els_lp +: lg_els_lp]          = slot_src[b];
  end

endmodule

`default_nettype wire
